// File: rtl/vram_port_arbiter.sv
// Purpose: shares the single VRAM user port between the host bus (A), the blitter/DMA (B) and a built-in fill engine.
// Latency: x_gnt pulses the cycle after the issue edge; read data and x_rvalid arrive 2 cycles after x_gnt.
// Backpressure: requesters hold x_req until x_gnt; the fill engine waits, but wins after CLR_STARVE straight losses.
//
// Ports:
//   clk, rst_n                       user-port clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata        host request; a_gnt, a_rvalid, a_rdata responses
//   b_req/b_we/b_addr/b_wdata        blitter request; b_gnt, b_rvalid, b_rdata responses
//   clr_start/base/len/value         fill command; clr_busy, clr_done status
//   vram_addr/wdata/we, vram_rdata   registered VRAM user port, read data one cycle after address
module vram_port_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int VRAM_DEPTH = 24576,
    parameter int CLR_STARVE = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    input  logic              clr_start,
    input  logic [ADDR_W-1:0] clr_base,
    input  logic [ADDR_W-1:0] clr_len,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              clr_done,

    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    output logic              vram_we,
    input  logic [DATA_W-1:0] vram_rdata
);

    localparam int                ST_W       = $clog2(CLR_STARVE + 1);
    localparam logic [ST_W-1:0]   STARVE_MAX = ST_W'(CLR_STARVE);
    localparam logic [ADDR_W:0]   DEPTH_X    = (ADDR_W + 1)'(VRAM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(VRAM_DEPTH - 1);

    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_t;

    clr_state_t        clr_state;
    logic [ST_W-1:0]   starve_cnt;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] clr_remain;
    logic [DATA_W-1:0] clr_val;

    // 0: A has priority on the next A/B contest, 1: B has priority
    logic rr_pri_b;

    logic a_elig;
    logic b_elig;
    logic clr_elig;
    logic win_a;
    logic win_b;
    logic win_c;

    // Read pipeline: p1 = address on the VRAM port, p2 = data on vram_rdata
    logic a_rd_p1;
    logic a_rd_p2;
    logic b_rd_p1;
    logic b_rd_p2;

    assign clr_busy = (clr_state == CLR_RUN);

    // A requester whose grant is showing this cycle has already been served for
    // its current request, so it sits out one arbitration.
    always_comb begin
        a_elig   = a_req && !a_gnt;
        b_elig   = b_req && !b_gnt;
        clr_elig = (clr_state == CLR_RUN);
        win_a    = 1'b0;
        win_b    = 1'b0;
        win_c    = 1'b0;
        if (clr_elig && (starve_cnt == STARVE_MAX)) begin
            win_c = 1'b1;
        end else if (a_elig && b_elig) begin
            if (rr_pri_b) begin
                win_b = 1'b1;
            end else begin
                win_a = 1'b1;
            end
        end else if (a_elig) begin
            win_a = 1'b1;
        end else if (b_elig) begin
            win_b = 1'b1;
        end else if (clr_elig) begin
            win_c = 1'b1;
        end
    end

    // Issue stage: load the VRAM port from the winner. With no winner only the
    // write enable drops; address and data keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_addr  <= '0;
            vram_wdata <= '0;
            vram_we    <= 1'b0;
            a_gnt      <= 1'b0;
            b_gnt      <= 1'b0;
            rr_pri_b   <= 1'b0;
        end else begin
            a_gnt   <= win_a;
            b_gnt   <= win_b;
            vram_we <= 1'b0;
            if (win_a) begin
                vram_addr  <= a_addr;
                vram_wdata <= a_wdata;
                vram_we    <= a_we;
                rr_pri_b   <= 1'b1;
            end else if (win_b) begin
                vram_addr  <= b_addr;
                vram_wdata <= b_wdata;
                vram_we    <= b_we;
                rr_pri_b   <= 1'b0;
            end else if (win_c) begin
                vram_addr  <= clr_addr;
                vram_wdata <= clr_val;
                vram_we    <= 1'b1;
            end
        end
    end

    // Read return path, one independent pipeline per requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rd_p1  <= 1'b0;
            a_rd_p2  <= 1'b0;
            a_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rd_p1  <= 1'b0;
            b_rd_p2  <= 1'b0;
            b_rvalid <= 1'b0;
            b_rdata  <= '0;
        end else begin
            a_rd_p1  <= win_a && !a_we;
            a_rd_p2  <= a_rd_p1;
            a_rvalid <= a_rd_p2;
            if (a_rd_p2) begin
                a_rdata <= vram_rdata;
            end
            b_rd_p1  <= win_b && !b_we;
            b_rd_p2  <= b_rd_p1;
            b_rvalid <= b_rd_p2;
            if (b_rd_p2) begin
                b_rdata <= vram_rdata;
            end
        end
    end

    // Fill engine FSM with its starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_state  <= CLR_IDLE;
            starve_cnt <= '0;
            clr_addr   <= '0;
            clr_remain <= '0;
            clr_val    <= '0;
            clr_done   <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (clr_state)
                CLR_IDLE: begin
                    starve_cnt <= '0;
                    if (clr_start) begin
                        if ((clr_len != '0) && ({1'b0, clr_base} < DEPTH_X)) begin
                            clr_addr   <= clr_base;
                            clr_remain <= clr_len;
                            clr_val    <= clr_value;
                            clr_state  <= CLR_RUN;
                        end else begin
                            // Empty or out-of-range fill completes without touching VRAM
                            clr_done <= 1'b1;
                        end
                    end
                end
                CLR_RUN: begin
                    if (win_c) begin
                        starve_cnt <= '0;
                        clr_addr   <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + 1'b1;
                        clr_remain <= clr_remain - 1'b1;
                        if (clr_remain == ADDR_W'(1)) begin
                            clr_state <= CLR_IDLE;
                            clr_done  <= 1'b1;
                        end
                    end else begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                default: clr_state <= CLR_IDLE;
            endcase
        end
    end

endmodule
